cic_decim: RTL

- Parametrised multi-channel CIC decimator for PDM MEMS microphone streams.
- Successor to the fixed 2nd-order, decimate-by-32, single-channel demodulator.
- Uses a true Hogenauer structure: ORDER integrators at the input rate, a decimation-phase counter, then ORDER combs at the output rate.
- Sits between the PDM capture front-end and the beamforming/FIR stages; one instance serves all microphones sharing a PDM clock.

---
 rtl/cic_decim.sv | 94 +++++++++
 1 files changed

// File: rtl/cic_decim.sv
// Multi-channel Hogenauer CIC decimator for PDM microphone streams.
// Optional CIC_SYNC_IN_EN adds a sync input that realigns phase and clears filter state.
module cic_decim #(
    parameter int ORDER    = 2,
    parameter int DECIM    = 32,
    parameter int CHANNELS = 2,
    localparam int OUT_W   = 2 + ORDER * $clog2(DECIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [CHANNELS-1:0]       data_in,
`ifdef CIC_SYNC_IN_EN
    input  logic                      sync,
`endif
    output logic                      out_valid,
    output logic [CHANNELS*OUT_W-1:0] data_out
);
    localparam int PW = $clog2(DECIM);

    typedef logic [OUT_W-1:0] word_t;

    word_t         integ_q  [CHANNELS][ORDER];
    word_t         dly_q    [CHANNELS][ORDER];
    word_t         comb_in  [CHANNELS][ORDER];
    word_t         comb_res [CHANNELS];
    word_t         x        [CHANNELS];
    word_t         acc;
    logic [PW-1:0] phase_q;
    logic          strobe;

    assign strobe = we && (phase_q == PW'(DECIM - 1));

    // Comb chain runs from the pre-update last integrator; comb_in is what each delay captures.
    always_comb begin
        acc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            x[c] = {{(OUT_W-1){~data_in[c]}}, 1'b1};
            acc  = integ_q[c][ORDER-1];
            for (int k = 0; k < ORDER; k++) begin
                comb_in[c][k] = acc;
                acc           = acc - dly_q[c][k];
            end
            comb_res[c] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
            phase_q   <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end
`ifdef CIC_SYNC_IN_EN
        else if (sync) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
            phase_q   <= '0;
            out_valid <= 1'b0;
        end
`endif
        else begin
            out_valid <= 1'b0;
            if (we) begin
                phase_q <= phase_q + PW'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    integ_q[c][0] <= integ_q[c][0] + x[c];
                    for (int k = 1; k < ORDER; k++) begin
                        integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
                    end
                end
                if (strobe) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        for (int k = 0; k < ORDER; k++) begin
                            dly_q[c][k] <= comb_in[c][k];
                        end
                        data_out[c*OUT_W +: OUT_W] <= comb_res[c];
                    end
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule
